// File: rtl/vseq_pkg.sv
// Shared op codes, FSM state type and op-decode helper for the vector op sequencer.
package vseq_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned PERF_W = 32;

  localparam logic [OP_W-1:0] OP_VADD = 3'b010;
  localparam logic [OP_W-1:0] OP_VMUL = 3'b000;
  localparam logic [OP_W-1:0] OP_VSUM = 3'b011;
  localparam logic [OP_W-1:0] OP_VSET = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ACC = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_FIN      = 3'd4
  } vseq_state_t;

  function automatic logic is_vec_op(input logic [OP_W-1:0] code);
    return code inside {OP_VADD, OP_VMUL, OP_VSUM, OP_VSET};
  endfunction

endpackage

// File: rtl/vseq_idx_ctr.sv
// Element index up-counter with clear, enable and a terminal flag on the next value.
module vseq_idx_ctr #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CW    = $clog2(LIMIT) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nxt,
  output logic          term
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;
  assign term    = (cnt_d == CW'(LIMIT));

endmodule

// File: rtl/vec_op_sequencer.sv
// Steps vector FP ops element by element through one shared FP lane ALU.
// Optional busy-cycle counter output perf_cycles when VSEQ_PERF_EN is defined.
module vec_op_sequencer
  import vseq_pkg::*;
#(
  parameter  int unsigned LANES = 4,
  localparam int unsigned IW    = $clog2(LANES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            alu_valid,
  input  logic            alu_ready,
  output logic [OP_W-1:0] alu_ctrl,
  output logic [IW-1:0]   alu_idx,
  output logic            acc_sel,
  input  logic            res_valid,
  output logic            wb_en,
  output logic [IW-1:0]   wb_idx
`ifdef VSEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cycles
`endif
);

  localparam int unsigned CW = IW + 1;

  vseq_state_t state_q, state_d;

  logic [CW-1:0] issue_cnt, issue_nxt, ret_cnt, ret_nxt;
  logic          issue_term, ret_term;
  logic          start_ok, accept, fire, stray, res_acc;

  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            alu_valid_q, alu_valid_d, acc_sel_q, acc_sel_d, wb_en_q, wb_en_d;
  logic [OP_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [IW-1:0]   alu_idx_q, alu_idx_d, wb_idx_q, wb_idx_d;

  // Outstanding count is issued minus returned; equal counters mean nothing in flight.
  assign start_ok = (state_q == ST_IDLE) || (state_q == ST_FIN);
  assign accept   = start && start_ok && is_vec_op(op);
  assign fire     = (state_q == ST_ISSUE) && alu_ready;
  assign stray    = res_valid && (issue_cnt == ret_cnt);
  assign res_acc  = res_valid && !stray;

  vseq_idx_ctr #(.LIMIT(LANES), .CW(CW)) u_issue_ctr (
    .clk(clk), .reset(reset), .clr(accept), .en(fire),
    .cnt(issue_cnt), .cnt_nxt(issue_nxt), .term(issue_term)
  );

  vseq_idx_ctr #(.LIMIT(LANES), .CW(CW)) u_ret_ctr (
    .clk(clk), .reset(reset), .clr(accept), .en(res_acc),
    .cnt(ret_cnt), .cnt_nxt(ret_nxt), .term(ret_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_FIN: state_d = accept ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        if (fire) begin
          if (alu_ctrl_q == OP_VSUM) begin
            state_d = ST_WAIT_ACC;
          end else if (issue_cnt == CW'(LANES - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_WAIT_ACC: if (res_acc) state_d = issue_term ? ST_FIN : ST_ISSUE;
      ST_DRAIN:    if (issue_nxt == ret_nxt) state_d = ST_FIN;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Next-cycle output values, registered below.
  always_comb begin
    busy_d      = (state_d == ST_ISSUE) || (state_d == ST_WAIT_ACC) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_FIN);
    err_d       = (start && start_ok && !is_vec_op(op)) || stray;
    alu_valid_d = (state_d == ST_ISSUE);
    alu_ctrl_d  = accept ? op : alu_ctrl_q;
    alu_idx_d   = issue_nxt[IW-1:0];
    acc_sel_d   = alu_valid_d && (alu_ctrl_d == OP_VSUM) && (issue_nxt != '0);
    wb_en_d     = res_acc && ((alu_ctrl_q != OP_VSUM) || ret_term);
    wb_idx_d    = (alu_ctrl_q == OP_VSUM) ? '0 : ret_cnt[IW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      alu_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      alu_idx_q   <= '0;
      acc_sel_q   <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_idx_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      alu_valid_q <= alu_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_idx_q   <= alu_idx_d;
      acc_sel_q   <= acc_sel_d;
      wb_en_q     <= wb_en_d;
      wb_idx_q    <= wb_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign alu_valid = alu_valid_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_idx   = alu_idx_q;
  assign acc_sel   = acc_sel_q;
  assign wb_en     = wb_en_q;
  assign wb_idx    = wb_idx_q;

`ifdef VSEQ_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;

  // Busy cycles of the latest op; held after completion, saturating.
  always_comb begin
    perf_d = perf_q;
    if (accept) begin
      perf_d = '0;
    end else if (busy_q && (perf_q != '1)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Self-checking bench for vec_op_sequencer with a latency-programmable ALU stand-in.
// Build with VSEQ_PERF_EN defined to also check perf_cycles.
`timescale 1ns/1ps
module tb_vec_op_sequencer;
  import vseq_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned IW    = $clog2(LANES);

  logic clk = 1'b0;
  logic reset, start, alu_ready, res_valid;
  logic [2:0] op;
  logic busy, done, err, alu_valid, acc_sel, wb_en;
  logic [2:0] alu_ctrl;
  logic [IW-1:0] alu_idx, wb_idx;
`ifdef VSEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif
  logic [15:0] all_outs;

  vec_op_sequencer #(.LANES(LANES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .busy(busy), .done(done), .err(err),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_ctrl(alu_ctrl),
    .alu_idx(alu_idx), .acc_sel(acc_sel), .res_valid(res_valid),
    .wb_en(wb_en), .wb_idx(wb_idx)
`ifdef VSEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  assign all_outs = 16'({busy, done, err, alu_valid, acc_sel, wb_en, alu_ctrl, alu_idx, wb_idx});

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int lat = 1;
  int resq[$];
  int iss_idx[$], iss_acc[$], iss_cyc[$], res_cyc[$], wb_idx_l[$], wb_cyc[$];
  int done_cyc, busy_cnt, err_cnt, valid_cnt, ctrl_bad, perf_at_done;

  // One clock: an accepted issue returns its result exactly lat cycles later.
  task automatic tick();
    bit fire;
    fire = alu_valid && alu_ready;
    if (fire) resq.push_back(cycle + lat);
    @(posedge clk); #1;
    cycle++;
    res_valid = 1'b0;
    if (resq.size() > 0 && resq[0] == cycle) begin
      void'(resq.pop_front());
      res_valid = 1'b1;
    end
  endtask

  // Issue one op and log its trace until done (or a cycle budget runs out).
  task automatic run_op(input logic [2:0] o, input int l, input int stall_idx,
                        input int stall_len, input bit rnd);
    int stalled;
    stalled = 0;
    lat = l;
    iss_idx.delete(); iss_acc.delete(); iss_cyc.delete();
    res_cyc.delete(); wb_idx_l.delete(); wb_cyc.delete();
    done_cyc = -1; busy_cnt = 0; err_cnt = 0; valid_cnt = 0; ctrl_bad = 0; perf_at_done = -1;
    cycle = 0; start = 1'b1; op = o; alu_ready = 1'b1;
    tick();
    start = 1'b0;
    while (done_cyc < 0 && cycle < 200) begin
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (alu_valid) valid_cnt++;
      if (alu_valid && alu_ctrl !== o) ctrl_bad++;
      if (res_valid) res_cyc.push_back(cycle);
      if (wb_en) begin wb_idx_l.push_back(int'(wb_idx)); wb_cyc.push_back(cycle); end
      if (done) begin
        done_cyc = cycle;
`ifdef VSEQ_PERF_EN
        perf_at_done = int'(perf_cycles);
`endif
      end
      if (rnd) alu_ready = ($urandom_range(0, 2) != 0);
      else begin
        alu_ready = !(alu_valid && int'(alu_idx) == stall_idx && stalled < stall_len);
        if (!alu_ready) stalled++;
      end
      if (alu_valid && alu_ready) begin
        iss_idx.push_back(int'(alu_idx)); iss_acc.push_back(int'(acc_sel)); iss_cyc.push_back(cycle);
      end
      if (done_cyc < 0) tick();
    end
    alu_ready = 1'b1;
    checks++;
    if (done_cyc < 0) begin failures++; $display("FAIL run_timeout op=%0b: no done within budget", o); end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (all_outs !== 16'h0) begin failures++; $display("FAIL reset_outs_during: got %h expected 0", all_outs); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (all_outs !== 16'h0) begin failures++; $display("FAIL reset_outs_after: got %h expected 0", all_outs); end
`ifdef VSEQ_PERF_EN
    checks++;
    if (perf_cycles !== 32'd0) begin failures++; $display("FAIL reset_perf: got %0d expected 0", perf_cycles); end
`endif
  endtask

  task automatic test_vadd();
    run_op(OP_VADD, 1, -1, 0, 1'b0);
    checks++;
    if (done_cyc != 6) begin failures++; $display("FAIL vadd_done_cycle: got %0d expected 6", done_cyc); end
    checks++;
    if (busy_cnt != 5) begin failures++; $display("FAIL vadd_busy_cycles: got %0d expected 5", busy_cnt); end
    checks++;
    if (iss_cyc.size() != 4 || wb_cyc.size() != 4) begin
      failures++; $display("FAIL vadd_counts: issues %0d wbs %0d expected 4 4", iss_cyc.size(), wb_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (iss_cyc[k] != k + 1 || iss_idx[k] != k || wb_cyc[k] != k + 3 || wb_idx_l[k] != k) begin
          failures++;
          $display("FAIL vadd_elem%0d: issue cyc %0d idx %0d wb cyc %0d idx %0d expected %0d %0d %0d %0d",
                   k, iss_cyc[k], iss_idx[k], wb_cyc[k], wb_idx_l[k], k + 1, k, k + 3, k);
        end
      end
    end
`ifdef VSEQ_PERF_EN
    checks++;
    if (perf_at_done != 5) begin failures++; $display("FAIL vadd_perf: got %0d expected 5", perf_at_done); end
`endif
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL vadd_after: done %b busy %b expected 0 0", done, busy); end
`ifdef VSEQ_PERF_EN
    checks++;
    if (perf_cycles !== 32'd5) begin failures++; $display("FAIL vadd_perf_hold: got %0d expected 5", perf_cycles); end
`endif
  endtask

  task automatic test_vsum();
    int exp_acc[4] = '{0, 1, 1, 1};
    run_op(OP_VSUM, 1, -1, 0, 1'b0);
    checks++;
    if (done_cyc != 9) begin failures++; $display("FAIL vsum_done_cycle: got %0d expected 9", done_cyc); end
    checks++;
    if (wb_cyc.size() != 1 || wb_idx_l[0] != 0 || wb_cyc[0] != 9) begin
      failures++; $display("FAIL vsum_wb: got %0d writes expected 1 at cycle 9 idx 0", wb_cyc.size());
    end
    checks++;
    if (iss_cyc.size() != 4) begin failures++; $display("FAIL vsum_issues: got %0d expected 4", iss_cyc.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (iss_cyc[k] != 2 * k + 1 || iss_acc[k] != exp_acc[k] || iss_idx[k] != k) begin
          failures++;
          $display("FAIL vsum_elem%0d: cyc %0d acc %0d idx %0d expected %0d %0d %0d",
                   k, iss_cyc[k], iss_acc[k], iss_idx[k], 2 * k + 1, exp_acc[k], k);
        end
      end
    end
    tick();
  endtask

  task automatic test_stall();
    int exp_cyc[4] = '{1, 2, 6, 7};
    run_op(OP_VMUL, 1, 2, 3, 1'b0);
    checks++;
    if (done_cyc != 9) begin failures++; $display("FAIL stall_done_cycle: got %0d expected 9", done_cyc); end
    checks++;
    if (valid_cnt != 7) begin failures++; $display("FAIL stall_valid_cycles: got %0d expected 7", valid_cnt); end
    checks++;
    if (iss_cyc.size() != 4) begin failures++; $display("FAIL stall_issues: got %0d expected 4", iss_cyc.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (iss_cyc[k] != exp_cyc[k] || iss_idx[k] != k) begin
          failures++; $display("FAIL stall_elem%0d: cyc %0d idx %0d expected %0d %0d", k, iss_cyc[k], iss_idx[k], exp_cyc[k], k);
        end
      end
    end
    tick();
  endtask

  task automatic test_bad_op();
    start = 1'b1; op = 3'b001;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || alu_valid !== 1'b0) begin
      failures++; $display("FAIL bad_op: err %b busy %b valid %b expected 1 0 0", err, busy, alu_valid);
    end
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bad_op_after: err %b busy %b expected 0 0", err, busy); end
  endtask

  task automatic test_stray_res();
    res_valid = 1'b1;
    tick();
    checks++;
    if (err !== 1'b1 || wb_en !== 1'b0) begin failures++; $display("FAIL stray_res: err %b wb_en %b expected 1 0", err, wb_en); end
    tick();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL stray_res_after: err %b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    int seen_done, seen_wb;
    seen_done = 0; seen_wb = 0;
    lat = 1; resq.delete(); cycle = 0;
    start = 1'b1; op = OP_VADD; alu_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (all_outs !== 16'h0) begin failures++; $display("FAIL reset_mid_outs: got %h expected 0", all_outs); end
    resq.delete(); res_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen_done++;
      if (wb_en || busy) seen_wb++;
    end
    checks++;
    if (seen_done != 0 || seen_wb != 0) begin failures++; $display("FAIL reset_mid_quiet: done %0d wb/busy %0d expected 0 0", seen_done, seen_wb); end
    run_op(OP_VSET, 1, -1, 0, 1'b0);
    checks++;
    if (done_cyc != 6 || wb_cyc.size() != 4) begin
      failures++; $display("FAIL reset_mid_vset: done %0d wbs %0d expected 6 4", done_cyc, wb_cyc.size());
    end
  endtask

  // Random ops, ALU latency and ready pattern checked against transaction-level rules.
  task automatic test_random();
    logic [2:0] ops[4] = '{OP_VADD, OP_VMUL, OP_VSUM, OP_VSET};
    logic [2:0] o;
    int l, exp_wb, last_res;
    bit is_sum;
    for (int it = 0; it < 40; it++) begin
      o = ops[$urandom_range(0, 3)];
      l = $urandom_range(1, 3);
      is_sum = (o == OP_VSUM);
      run_op(o, l, -1, 0, 1'b1);
      exp_wb = is_sum ? 1 : LANES;
      checks++;
      if (iss_idx.size() != LANES || res_cyc.size() != LANES || wb_cyc.size() != exp_wb) begin
        failures++;
        $display("FAIL rnd%0d_counts op=%0b: issues %0d results %0d wbs %0d expected %0d %0d %0d",
                 it, o, iss_idx.size(), res_cyc.size(), wb_cyc.size(), LANES, LANES, exp_wb);
        continue;
      end
      last_res = res_cyc[LANES-1];
      for (int k = 0; k < LANES; k++) begin
        checks++;
        if (iss_idx[k] != k || iss_acc[k] != int'(is_sum && k != 0)) begin
          failures++; $display("FAIL rnd%0d_issue%0d: idx %0d acc %0d expected %0d %0d", it, k, iss_idx[k], iss_acc[k], k, int'(is_sum && k != 0));
        end
        if (is_sum && k > 0) begin
          checks++;
          if (iss_cyc[k] <= res_cyc[k-1]) begin
            failures++; $display("FAIL rnd%0d_vsum_order%0d: issue cyc %0d prior result cyc %0d", it, k, iss_cyc[k], res_cyc[k-1]);
          end
        end
        if (!is_sum) begin
          checks++;
          if (wb_idx_l[k] != k || wb_cyc[k] != res_cyc[k] + 1) begin
            failures++; $display("FAIL rnd%0d_wb%0d: idx %0d cyc %0d expected %0d %0d", it, k, wb_idx_l[k], wb_cyc[k], k, res_cyc[k] + 1);
          end
        end
      end
      if (is_sum) begin
        checks++;
        if (wb_idx_l[0] != 0 || wb_cyc[0] != last_res + 1) begin
          failures++; $display("FAIL rnd%0d_vsum_wb: idx %0d cyc %0d expected 0 %0d", it, wb_idx_l[0], wb_cyc[0], last_res + 1);
        end
      end else begin
        checks++;
        if (valid_cnt != iss_cyc[LANES-1]) begin
          failures++; $display("FAIL rnd%0d_valid_run: got %0d expected %0d", it, valid_cnt, iss_cyc[LANES-1]);
        end
      end
      checks++;
      if (done_cyc != last_res + 1 || busy_cnt != done_cyc - 1 || err_cnt != 0 || ctrl_bad != 0) begin
        failures++;
        $display("FAIL rnd%0d_done op=%0b: done %0d busy %0d err %0d ctrl_bad %0d expected %0d %0d 0 0",
                 it, o, done_cyc, busy_cnt, err_cnt, ctrl_bad, last_res + 1, last_res);
      end
`ifdef VSEQ_PERF_EN
      checks++;
      if (perf_at_done != done_cyc - 1) begin failures++; $display("FAIL rnd%0d_perf: got %0d expected %0d", it, perf_at_done, done_cyc - 1); end
`endif
      if ($urandom_range(0, 1) != 0) tick();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; alu_ready = 1'b0; res_valid = 1'b0;
    test_reset();
    test_vadd();
    test_vsum();
    test_stall();
    test_bad_op();
    test_stray_res();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_op_sequencer.md
Name: vec_op_sequencer

Overview:
- Multi-cycle controller that runs vector FP instructions (vadd.fp, vmul.fp, vsum.fp, vset.fp) element by element through one shared FP lane ALU.
- Sits between the control unit and the FP ALU lane.
- Stalls the pipeline while a vector op is in flight and drives per-element ALU control, element index, accumulate select and write-back strobes.
- Scalar ops bypass this block.

Parameters:
- LANES, 4, elements per vector register; power of two, 2..16.
- IW, $clog2(LANES), element index width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle issue pulse from control; asserted only for vector functs.
- op  in  3  ALU control code: 010 vadd, 000 vmul, 011 vsum, 111 vset.
- busy  out  1  pipeline stall request.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when start carries an unsupported op.
- alu_valid  out  1  operand pair for element alu_idx presented to ALU.
- alu_ready  in  1  ALU accepts the issue this cycle.
- alu_ctrl  out  3  ALU control for the current issue.
- alu_idx  out  IW  source element index.
- acc_sel  out  1  ALU operand A = accumulator (vsum elements 1..LANES-1).
- res_valid  in  1  ALU result available; in-order, at most one per cycle.
- wb_en  out  1  write ALU result to the destination register.
- wb_idx  out  IW  destination element index.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-operation aborts immediately, with no done pulse and no further wb_en.
- All outputs are registered or decoded from registered state only. No combinational path from alu_ready or res_valid to any output.
- States: IDLE, ISSUE, WAIT_ACC, DRAIN, FIN.
- IDLE:
  - busy=0.
  - start with a valid op: latch op into alu_ctrl, zero issue_idx, ret_idx and outstanding count, go to ISSUE; busy=1 from the next cycle.
  - start with an invalid op: err=1 next cycle, stay IDLE.
  - start outside IDLE is ignored.
- ISSUE:
  - alu_valid=1, alu_idx=issue_idx.
  - On alu_ready: issue_idx++ and outstanding++.
  - vadd/vmul/vset: issues back-to-back. After the issue with idx LANES-1 is accepted, go to DRAIN.
  - vsum: after each accepted issue, go to WAIT_ACC.
  - acc_sel=1 when op is vsum and issue_idx != 0.
- WAIT_ACC (vsum only):
  - alu_valid=0.
  - On res_valid: if issue_idx == LANES (all issued), go to FIN; otherwise return to ISSUE.
- Result handling, any busy state:
  - res_valid decrements outstanding and increments ret_idx.
  - Element-wise ops: wb_en=1 for each result, wb_idx=ret_idx.
  - vsum: wb_en=1 only on the final (LANES-th) result, wb_idx=0.
  - res_valid with outstanding==0 is ignored; err pulses once.
  - Simultaneous issue accept and res_valid: outstanding unchanged.
- DRAIN: alu_valid=0. When outstanding reaches 0 (including that cycle's res_valid), go to FIN.
- FIN: done=1 and busy=0 for one cycle, then IDLE. A start in the FIN cycle is accepted as if in IDLE.
- Counters are IW+1 bits wide so a count of LANES is representable; no wrap inside one op.
- Minimum latency with alu_ready=1 and a 1-cycle ALU:
  - element-wise op: done at start+LANES+2;
  - vsum: done at start+2·LANES+1.

Optional Feature:
- Macro: VSEQ_PERF_EN.
- Defined: extra output perf_cycles (out, 32). Counts cycles with busy=1 for the most recent op. Cleared on accepted start, held after FIN, 0 on reset, saturates at all-ones.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package vseq_pkg holds:
  - localparams for op codes OP_VADD=3'b010, OP_VMUL=3'b000, OP_VSUM=3'b011, OP_VSET=3'b111;
  - state enum vseq_state_t;
  - function is_vec_op().
- One natural sub-module, vseq_idx_ctr: a parameterised up counter with clear, enable and terminal flag at LANES. Instantiated for issue_idx and ret_idx.

Test Plan:
- LANES=4, start op=010, alu_ready=1, ALU latency 1 → alu_idx 0,1,2,3 on consecutive cycles; wb_en four cycles with wb_idx 0..3; done at cycle 6; busy high cycles 1..5.
- start op=011 (vsum), ALU latency 1 → acc_sel 0,1,1,1; one issue per two cycles; single wb_en with wb_idx=0; done at cycle 9.
- vmul with alu_ready low for 3 cycles at idx 2 → alu_idx held at 2, alu_valid stays 1, no skipped or duplicated index, done delayed by 3 cycles.
- start op=001 → err=1 next cycle; busy and alu_valid stay 0.
- reset asserted after 2 of 4 vadd issues → all outputs 0 asynchronously; no done; a fresh vset then completes normally.
- Stray res_valid in IDLE → err pulse, no wb_en. With VSEQ_PERF_EN, vadd run as in the first test → perf_cycles=5.
